// File: rtl/hash_msg_sequencer_if.sv
// hash_msg_sequencer_if: host-side and core-side signals of the hash message sequencer
interface hash_msg_sequencer_if;
   logic        start;
   logic [63:0] msg_len;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        m_valid;
   logic [7:0]  m_data;
   logic [63:0] m_counter;
   logic        core_hash_ready;
   logic [31:0] core_digest;
   logic [31:0] digest;
   logic        digest_valid;
   logic        busy;
   logic        err_timeout;
   modport master (
      output start, msg_len, in_valid, in_data, core_hash_ready, core_digest,
      input  in_ready, m_valid, m_data, m_counter, digest, digest_valid, busy, err_timeout
   );
   modport slave (
      input  start, msg_len, in_valid, in_data, core_hash_ready, core_digest,
      output in_ready, m_valid, m_data, m_counter, digest, digest_valid, busy, err_timeout
   );
endinterface

// File: rtl/hash_msg_sequencer.sv
// hash_msg_sequencer: buffers a host message and paces its bytes into the DES-S-box hash core
module hash_msg_sequencer #(
   parameter int DEPTH       = 16,
   parameter int BYTE_CYCLES = 3,
   parameter int TIMEOUT     = 255
) (
   input logic clk,
   input logic rst_n,
   hash_msg_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = BYTE_CYCLES > 1 ? $clog2(BYTE_CYCLES) : 1;
   localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   typedef enum logic [1:0] {IDLE, FEED, WAIT} state_t;
   state_t state, state_next;
   logic [7:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [63:0] accepted, remaining;
   logic [PW-1:0] pace;
   logic [TW-1:0] tcnt;
   logic hr_prev, full, empty, push, pop, hr_rise, timed_out, take_start;
   // pointers carry an extra wrap bit so full and empty are distinguishable
   assign empty      = wr_ptr == rd_ptr;
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign bus.in_ready = state == FEED && !full && accepted < bus.m_counter;
   assign push       = bus.in_valid && bus.in_ready;
   assign pop        = state == FEED && !empty && pace == '0 && remaining != '0;
   assign hr_rise    = bus.core_hash_ready && !hr_prev;
   assign timed_out  = tcnt == TW'(TIMEOUT);
   assign take_start = state == IDLE && bus.start && bus.msg_len != '0;
   assign bus.busy   = state != IDLE;
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (take_start) state_next = FEED;
         FEED:    if (pop && remaining == 64'd1) state_next = WAIT;
         WAIT:    if (hr_rise || timed_out) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_next;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         accepted         <= '0;
         remaining        <= '0;
         pace             <= '0;
         tcnt             <= '0;
         hr_prev          <= 1'b0;
         bus.m_valid      <= 1'b0;
         bus.m_data       <= '0;
         bus.m_counter    <= '0;
         bus.digest       <= '0;
         bus.digest_valid <= 1'b0;
         bus.err_timeout  <= 1'b0;
      end else begin
         hr_prev          <= bus.core_hash_ready;
         bus.m_valid      <= pop;
         bus.digest_valid <= state == WAIT && hr_rise;
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            accepted <= accepted + 64'd1;
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            bus.m_data <= mem[rd_ptr[AW-1:0]];
            pace       <= PW'(BYTE_CYCLES - 1);
            remaining  <= remaining - 64'd1;
         end else if (pace != '0) pace <= pace - 1'b1;
         if (take_start) begin
            bus.m_counter   <= bus.msg_len;
            remaining       <= bus.msg_len;
            accepted        <= '0;
            pace            <= '0;
            bus.err_timeout <= 1'b0;
         end
         tcnt <= state == WAIT ? tcnt + 1'b1 : '0;
         if (state == WAIT && hr_rise) bus.digest <= bus.core_digest;
         if (state == WAIT && !hr_rise && timed_out) bus.err_timeout <= 1'b1;
      end
   end
endmodule

// File: tb/tb_hash_msg_sequencer.sv
// tb_hash_msg_sequencer: directed and randomized messages checked against a byte-stream model
module tb_hash_msg_sequencer;
   localparam int DEPTH = 16, BC = 3, TO = 255;
   logic clk = 1'b0, rst_n = 1'b0;
   hash_msg_sequencer_if bus();
   hash_msg_sequencer #(.DEPTH(DEPTH), .BYTE_CYCLES(BC), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   int n_cmp = 0, n_err = 0, cyc = 0, dv_count = 0;
   logic [63:0] cur_len = '0;
   logic [7:0] src[$];
   logic [7:0] mv_data[$];
   int mv_cyc[$];

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(string p);
      check({p, "_in_ready"}, 64'(bus.in_ready), 0);
      check({p, "_m_valid"}, 64'(bus.m_valid), 0);
      check({p, "_m_data"}, 64'(bus.m_data), 0);
      check({p, "_m_counter"}, bus.m_counter, 0);
      check({p, "_digest"}, 64'(bus.digest), 0);
      check({p, "_digest_valid"}, 64'(bus.digest_valid), 0);
      check({p, "_busy"}, 64'(bus.busy), 0);
      check({p, "_err_timeout"}, 64'(bus.err_timeout), 0);
   endtask

   task automatic fill(int n);
      src.delete();
      repeat (n) src.push_back(8'($urandom));
   endtask

   // observed core-side byte stream, with cycle stamps for pacing checks
   always @(negedge clk) begin
      cyc++;
      if (bus.m_valid === 1'b1) begin
         mv_data.push_back(bus.m_data);
         mv_cyc.push_back(cyc);
         check("m_counter", bus.m_counter, cur_len);
      end
      if (bus.digest_valid === 1'b1) dv_count++;
   end

   task automatic run_msg(int len, int stall, bit exact, bit do_dig, logic [31:0] dg, bit inject);
      int pushes = 0, occ, dv0, last = -100000;
      bit done = 0;
      logic [31:0] dig_before;
      mv_data.delete();
      mv_cyc.delete();
      cur_len = 64'(len);
      dv0 = dv_count;
      @(negedge clk);
      bus.start = 1'b1;
      bus.msg_len = 64'(len);
      @(negedge clk);
      bus.start = 1'b0;
      bus.msg_len = {$urandom, $urandom};
      #1;
      check("busy_after_start", 64'(bus.busy), 1);
      check("err_cleared", 64'(bus.err_timeout), 0);
      check("m_counter_latched", bus.m_counter, 64'(len));
      for (int k = 0; k < 4000; k++) begin
         occ = pushes - mv_data.size();
         check("in_ready", 64'(bus.in_ready), 64'(mv_data.size() < len && occ < DEPTH && pushes < len));
         if (mv_data.size() >= len) begin
            done = 1;
            break;
         end
         bus.start = inject && k == 3;
         bus.msg_len = 64'd5;
         bus.in_valid = $urandom_range(99) >= stall;
         bus.in_data = pushes < src.size() ? src[pushes] : 8'h00;
         if (bus.in_valid && bus.in_ready) pushes++;
         @(negedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.start = 1'b0;
      if (!done) check("feed_bound", 0, 1);
      check("n_bytes", 64'(mv_data.size()), 64'(len));
      check("accepted", 64'(pushes), 64'(len));
      for (int i = 0; i < mv_data.size() && i < len; i++) check("byte", 64'(mv_data[i]), 64'(src[i]));
      for (int i = 1; i < mv_cyc.size(); i++)
         if (exact) check("gap", 64'(mv_cyc[i] - mv_cyc[i-1]), 64'(BC));
         else check("gap_min", 64'(mv_cyc[i] - mv_cyc[i-1] >= BC), 1);
      if (mv_cyc.size() > 0) last = mv_cyc[mv_cyc.size()-1];
      if (do_dig) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         bus.core_digest = dg;
         bus.core_hash_ready = 1'b1;
         @(negedge clk);
         #1;
         check("digest_valid", 64'(bus.digest_valid), 1);
         check("digest", 64'(bus.digest), 64'(dg));
         check("busy_done", 64'(bus.busy), 0);
         @(negedge clk);
         #1;
         check("digest_valid_pulse", 64'(bus.digest_valid), 0);
         check("dv_count", 64'(dv_count - dv0), 1);
         bus.core_hash_ready = 1'b0;
      end else begin
         dig_before = bus.digest;
         for (int k = 0; k < TO + 50; k++) begin
            if (bus.err_timeout === 1'b1) break;
            @(negedge clk);
            #1;
         end
         check("err_timeout", 64'(bus.err_timeout), 1);
         check("timeout_cycle", 64'(cyc - last), 64'(TO + 1));
         check("busy_timeout", 64'(bus.busy), 0);
         check("digest_kept", 64'(bus.digest), 64'(dig_before));
         check("no_dv_timeout", 64'(dv_count - dv0), 0);
      end
   endtask

   initial begin
      int i;
      bus.start = 1'b0;
      bus.msg_len = '0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.core_hash_ready = 1'b0;
      bus.core_digest = '0;
      repeat (3) @(negedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      src = '{8'h61};
      run_msg(1, 0, 1, 1, 32'hA5C3_0F12, 0);
      src = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
      run_msg(3, 0, 1, 1, $urandom, 0);
      fill(44);
      run_msg(40, 0, 1, 1, $urandom, 0);
      fill(4);
      run_msg(2, 0, 1, 0, 32'h0, 0);
      fill(6);
      run_msg(4, 30, 0, 1, $urandom, 0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.msg_len = '0;
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check("zero_len_busy", 64'(bus.busy), 0);
      @(negedge clk);
      #1;
      check("zero_len_busy2", 64'(bus.busy), 0);
      fill(10);
      run_msg(7, 20, 0, 1, $urandom, 1);
      for (int r = 0; r < 4; r++) begin
         int len = $urandom_range(1, 30);
         fill(len + 4);
         run_msg(len, $urandom_range(0, 70), 0, 1, $urandom, 0);
      end
      fill(8);
      cur_len = 64'd5;
      mv_data.delete();
      mv_cyc.delete();
      @(negedge clk);
      bus.start = 1'b1;
      bus.msg_len = 64'd5;
      @(negedge clk);
      bus.start = 1'b0;
      i = 0;
      for (int k = 0; k < 200 && mv_data.size() < 2; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data = src[i];
         if (bus.in_ready) i++;
         @(negedge clk);
         #1;
      end
      check("pre_reset_bytes", 64'(mv_data.size()), 2);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      fill(3);
      run_msg(1, 0, 1, 1, $urandom, 0);
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
